// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Data-memory responder: the memory end of the CPU load/store interface.
// A single request is accepted through a valid/ready handshake, held for
// LATENCY wait states, and answered with a one-cycle response strobe. Word,
// half and byte stores merge into a word-organised array. Loads return the
// selected lane(s), sign- or zero-extended by access type.
//
// Parameters
//   DEPTH    number of 32-bit words (byte space 0 .. DEPTH*4-1)
//   LATENCY  wait-state cycles between accept and response (0..15)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; aborts any in-flight request
//   req_valid   request present
//   req_ready   responder idle (high only in IDLE)
//   req_we      1 = store, 0 = load
//   req_type    000 W, 001 H signed, 010 H unsigned, 011 B signed, 100 B unsigned
//   req_addr    byte address
//   req_wdata   store data (H uses [15:0], B uses [7:0])
//   req_pc      PC of the issuing instruction, used only by the write log
//   resp_valid  one-cycle response strobe
//   resp_rdata  load result; 0 for stores and errors; held between responses
//   resp_err    misaligned, out-of-range or illegal-type access
//
// Configuration
//   DM_WRITE_LOG_EN  when defined, every committed store prints
//                    "@<pc>: *<word addr> <= <merged word>". When undefined no
//                    display code is compiled and the hardware is identical.
// -----------------------------------------------------------------------------
module dm_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BYTE_SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LAT_CNT   = 4'(LATENCY);

  // Access-type encodings of req_type.
  localparam logic [2:0] TY_W  = 3'b000;
  localparam logic [2:0] TY_HS = 3'b001;
  localparam logic [2:0] TY_HU = 3'b010;
  localparam logic [2:0] TY_BS = 3'b011;
  localparam logic [2:0] TY_BU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Any of: illegal type, misaligned W/H, address beyond the array.
  function automatic logic access_err(input logic [2:0] ty, input logic [31:0] addr);
    logic bad_type;
    logic misaligned;
    logic out_of_range;
    bad_type     = (ty > TY_BU);
    misaligned   = ((ty == TY_W) && (addr[1:0] != 2'b00)) ||
                   (((ty == TY_HS) || (ty == TY_HU)) && addr[0]);
    out_of_range = ({1'b0, addr} >= BYTE_SPAN);
    return bad_type | misaligned | out_of_range;
  endfunction

  // Select the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  ty,
                                               input logic [1:0]  lane);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = lane[1] ? word[31:16] : word[15:0];
    byte_v = word[{lane, 3'b000} +: 8];
    case (ty)
      TY_W:    res = word;
      TY_HS:   res = {{16{half_v[15]}}, half_v};
      TY_HU:   res = {16'h0000, half_v};
      TY_BS:   res = {{24{byte_v[7]}}, byte_v};
      TY_BU:   res = {24'h000000, byte_v};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Merge store data into the existing word; untouched lanes keep old data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  ty,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    case (ty)
      TY_W:         res = wdata;
      TY_HS, TY_HU: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      TY_BS, TY_BU: res[{lane, 3'b000} +: 8]     = wdata[7:0];
      default:      res = word;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        we_q,         we_d;
  logic [2:0]  type_q,       type_d;
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q,   resp_err_d;

  logic [31:0] mem_q [DEPTH];

`ifdef DM_WRITE_LOG_EN
  logic [31:0] pc_q, pc_d;
`else
  // The PC only feeds the write log; fold it away when logging is off.
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  // Response-path values for the request that is about to enter RESP.
  logic        err_next;
  logic [31:0] rd_word_next;

  // Store-commit path, evaluated on the latched fields while in RESP.
  logic              commit_we;
  logic [ADDR_W-1:0] commit_idx;
  logic [31:0]       merged_word;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned; a missing default would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    type_d       = type_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef DM_WRITE_LOG_EN
    pc_d         = pc_q;
`endif

    case (state_q)
      S_IDLE: begin
        // req_ready is implied by being in IDLE.
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_CNT;
`ifdef DM_WRITE_LOG_EN
          pc_d    = req_pc;
`endif
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Leaving on cnt == 1 places the response LATENCY edges after accept.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response registers are loaded on the edge that enters RESP, from the
    // fields that will be latched at that edge. No store commits before RESP
    // ends, so the array content read here is the same as during RESP.
    err_next     = access_err(type_d, addr_d);
    rd_word_next = mem_q[addr_d[ADDR_W+1:2]];
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      resp_valid_d = 1'b1;
      resp_err_d   = err_next;
      resp_rdata_d = (we_d || err_next) ? '0
                                        : load_extract(rd_word_next, type_d, addr_d[1:0]);
    end

    commit_idx  = addr_q[ADDR_W+1:2];
    merged_word = merge_store(mem_q[commit_idx], wdata_q, type_q, addr_q[1:0]);
    commit_we   = (state_q == S_RESP) && we_q && !access_err(type_q, addr_q);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this edge.
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      type_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef DM_WRITE_LOG_EN
      pc_q         <= '0;
`endif
      // NOTE: the array is cleared by reset because software relies on a
      // zeroed memory; this forces flop storage rather than an SRAM macro.
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
`ifdef DM_WRITE_LOG_EN
      pc_q         <= pc_d;
`endif
      // Store commits on the edge that ends RESP.
      if (commit_we) begin
        mem_q[commit_idx] <= merged_word;
`ifdef DM_WRITE_LOG_EN
        $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged_word);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for dm_responder: the driver pushes the expected response
// for each accepted request; a negedge monitor pops and compares whenever the
// DUT raises resp_valid. Expected data comes from a byte-addressed model.
module tb_dm_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned SPAN  = DEPTH * 4;
  localparam int          CLK_P = 10;

  localparam logic [2:0] W  = 3'd0;
  localparam logic [2:0] HS = 3'd1;
  localparam logic [2:0] HU = 3'd2;
  localparam logic [2:0] BS = 3'd3;
  localparam logic [2:0] BU = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #(CLK_P/2) clk = ~clk;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    time         t_acc;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mm [SPAN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: little-endian byte memory; accesses are 4/2/1 bytes and
  // must be naturally aligned and fully inside the byte space.
  task automatic model_access(input logic we, input logic [2:0] ty, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int size;
    size = (ty == W) ? 4 : (ty <= HU) ? 2 : 1;
    err  = (ty > BU) || (a >= SPAN) || ((a % size) != 0);
    rd   = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mm[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd = rd | (32'(mm[a + i]) << (8*i));
      if (ty == HS && rd[15]) rd = rd | 32'hFFFF_0000;
      if (ty == BS && rd[7])  rd = rd | 32'hFFFF_FF00;
    end
  endtask

  // Monitor: req_ready must be low exactly while a request is in flight, and
  // each resp_valid cycle consumes one expected entry.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected resp_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({"rdata ", e.tag}, resp_rdata, e.rd);
          check({"err ", e.tag}, {31'd0, resp_err}, {31'd0, e.err});
          check({"latency ", e.tag}, 32'($time - e.t_acc), 32'(LAT*CLK_P + CLK_P/2));
        end
      end
    end
  end

  // All driver tasks start and end #1 after a rising edge.
  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    exp_q.delete();
    for (int i = 0; i < SPAN; i++) mm[i] = 8'h00;
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] ty, input logic [31:0] a,
                       input logic [31:0] wd, input logic hold, input logic use_exp,
                       input logic [31:0] x_rd, input logic x_err, input string tag);
    logic        rdy;
    logic        got;
    logic [31:0] m_rd;
    logic        m_err;
    exp_t        e;
    req_valid = 1'b1;
    req_we    = we;
    req_type  = ty;
    req_addr  = a;
    req_wdata = wd;
    req_pc    = $urandom;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
    if (!got) begin
      fail_now({"accept ", tag});
      req_valid = 1'b0;
      return;
    end
    model_access(we, ty, a, wd, m_rd, m_err);
    e.rd    = use_exp ? x_rd : m_rd;
    e.err   = use_exp ? x_err : m_err;
    e.t_acc = $time;
    e.tag   = tag;
    exp_q.push_back(e);
    #1;
    if (!hold) begin
      // Inputs need not stay stable after accept; scramble them.
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_type  = 3'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64; k++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    fail_now("drain");
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1);
  end

  initial begin
    logic        we;
    logic [2:0]  ty;
    logic [31:0] a;
    logic        hold;
    int          r;
    int          size;

    do_reset(2);
    mon_en = 1'b1;

    // Reset content and first-response latency.
    issue(0, W, 32'h0, 32'h0, 0, 1, 32'h0000_0000, 0, "t1 ld W 0x0");
    wait_idle();

    // Byte loads with sign and zero extension.
    issue(1, W,  32'h10, 32'h80FF_7F01, 0, 1, 32'h0, 0, "t2 st W 0x10");
    issue(0, BS, 32'h13, 32'h0, 0, 1, 32'hFFFF_FF80, 0, "t2 ld BS 0x13");
    issue(0, BU, 32'h12, 32'h0, 0, 1, 32'h0000_00FF, 0, "t2 ld BU 0x12");
    issue(0, BS, 32'h11, 32'h0, 0, 1, 32'h0000_007F, 0, "t2 ld BS 0x11");
    issue(0, BU, 32'h10, 32'h0, 0, 1, 32'h0000_0001, 0, "t2 ld BU 0x10");
    wait_idle();

    // Half store into upper lanes, other lanes preserved.
    issue(1, W,  32'h14, 32'h1122_3344, 0, 1, 32'h0, 0, "t3 st W 0x14");
    issue(1, HU, 32'h16, 32'hCAFE_BEEF, 0, 1, 32'h0, 0, "t3 st H 0x16");
    issue(0, W,  32'h14, 32'h0, 0, 1, 32'hBEEF_3344, 0, "t3 ld W 0x14");
    issue(0, HS, 32'h16, 32'h0, 0, 1, 32'hFFFF_BEEF, 0, "t3 ld HS 0x16");
    issue(0, HU, 32'h14, 32'h0, 0, 1, 32'h0000_3344, 0, "t3 ld HU 0x14");
    wait_idle();

    // Error cases, followed by readback that memory is unchanged.
    issue(1, W,  32'h21, 32'hFFFF_FFFF, 0, 1, 32'h0, 1, "t4 st W 0x21");
    issue(0, HS, 32'h03, 32'h0, 0, 1, 32'h0, 1, "t4 ld H 0x03");
    issue(0, 3'd7, 32'h10, 32'h0, 0, 1, 32'h0, 1, "t4 ld type7");
    issue(1, 3'd5, 32'h10, 32'h5555_5555, 0, 1, 32'h0, 1, "t4 st type5");
    issue(0, W,  SPAN, 32'h0, 0, 1, 32'h0, 1, "t4 ld W span");
    issue(1, W,  SPAN, 32'h1234_5678, 0, 1, 32'h0, 1, "t4 st W span");
    issue(1, BU, 32'hFFFF_FFFF, 32'h77, 0, 1, 32'h0, 1, "t4 st B top");
    issue(0, W,  32'h20, 32'h0, 0, 1, 32'h0000_0000, 0, "t4 rb W 0x20");
    issue(0, W,  32'h10, 32'h0, 0, 1, 32'h80FF_7F01, 0, "t4 rb W 0x10");
    issue(1, W,  SPAN-4, 32'h1234_5678, 0, 1, 32'h0, 0, "t4 st W last");
    issue(0, BU, SPAN-1, 32'h0, 0, 1, 32'h0000_0012, 0, "t4 ld BU last");
    wait_idle();

    // req_valid held high across back-to-back requests.
    issue(0, W,  32'h10, 32'h0, 1, 1, 32'h80FF_7F01, 0, "t5 b2b ld W");
    issue(0, HU, 32'h12, 32'h0, 1, 1, 32'h0000_80FF, 0, "t5 b2b ld HU");
    issue(1, BU, 32'h31, 32'h0000_00AA, 1, 1, 32'h0, 0, "t5 b2b st B");
    issue(0, W,  32'h30, 32'h0, 0, 1, 32'h0000_AA00, 0, "t5 b2b ld W");
    wait_idle();

    // Reset during WAIT of a store: aborted, and memory is cleared.
    issue(1, W, 32'h40, 32'hDEAD_BEEF, 0, 1, 32'h0, 0, "t5 st aborted");
    do_reset(1);
    issue(0, W, 32'h40, 32'h0, 0, 1, 32'h0000_0000, 0, "t5 ld W 0x40");
    issue(0, W, 32'h10, 32'h0, 0, 1, 32'h0000_0000, 0, "t5 ld W 0x10");
    wait_idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      ty = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      r  = $urandom_range(0, 15);
      if (r == 0)      a = SPAN - 8 + $urandom_range(0, 15);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 255);
      size = (ty == W) ? 4 : (ty <= HU) ? 2 : 1;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size) - 32'd1);
      hold = ($urandom_range(0, 2) == 0);
      issue(we, ty, a, $urandom, hold, 0, 32'h0, 0, "rand");
      if (!hold) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    wait_idle();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
